// File: rtl/fifo_entrada_if.sv
// ============================================================================
// Module   : fifo_entrada_if
// Brief    : Write/read handshake, data and status bundle of fifo_entrada.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_entrada_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output data_in, push, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, error, count
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, error, count
  );
endinterface

`default_nettype wire

// File: rtl/fifo_entrada.sv
// ============================================================================
// Module   : fifo_entrada
// Brief    : Synchronous FIFO with registered read port feeding one 2:1 mux input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_entrada #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  wire logic      clk,
  input  wire logic      reset_L,
  fifo_entrada_if.slave  bus
);

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL   = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL   = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  error;

  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;
  logic overflow;
  logic underflow;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign pop_ok    = bus.pop & ~empty;
  assign push_ok   = reset_L & bus.push & (~full | pop_ok);
  assign overflow  = bus.push & full & ~pop_ok;
  assign underflow = bus.pop & empty;

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      // Output is zeroed on idle cycles so the mux never sees stale data.
      if (pop_ok) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        data_out  <= mem[rd_ptr];
        valid_out <= 1'b1;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (overflow | underflow) begin
        error <= 1'b1;
      end
    end
  end

  assign bus.data_out     = data_out;
  assign bus.valid_out    = valid_out;
  assign bus.count        = count;
  assign bus.error        = error;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_LVL);
  assign bus.almost_empty = (count <= AE_LVL);

endmodule

`default_nettype wire

// File: tb/tb_fifo_entrada.sv
// ============================================================================
// Module   : tb_fifo_entrada
// Brief    : Directed self-checking bench for fifo_entrada.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_entrada;

  logic clk;
  logic reset_L;
  int   total;
  int   bad;

  fifo_entrada_if #(.DATA_WIDTH(2), .ADDR_WIDTH(3)) bus ();

  fifo_entrada #(
    .DATA_WIDTH(2),
    .ADDR_WIDTH(3),
    .AF_THRESH (6),
    .AE_THRESH (1)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge and outputs sampled at the same point.
  task automatic cyc(input logic p, input logic q, input logic [1:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    reset_L  = 1'b0;
    #2;
    reset_L  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_count"}, 32'(bus.count), 0);
    check_val({tag, "_empty"}, 32'(bus.empty), 1);
    check_val({tag, "_ae"},    32'(bus.almost_empty), 1);
    check_val({tag, "_full"},  32'(bus.full), 0);
    check_val({tag, "_af"},    32'(bus.almost_full), 0);
    check_val({tag, "_valid"}, 32'(bus.valid_out), 0);
    check_val({tag, "_dout"},  32'(bus.data_out), 0);
  endtask

  logic [1:0] fill_words [8];
  logic [1:0] q [$];
  logic [1:0] w;

  initial begin
    total = 0;
    bad   = 0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 2'b00;

    // Reset held with push active, then asynchronous reset mid-stream.
    reset_L = 1'b0;
    cyc(1'b1, 1'b0, 2'b11);
    cyc(1'b1, 1'b0, 2'b11);
    check_idle("rst_hold");
    check_val("rst_hold_err", 32'(bus.error), 0);
    reset_L = 1'b1;
    cyc(1'b1, 1'b0, 2'b11);
    cyc(1'b1, 1'b0, 2'b11);
    cyc(1'b1, 1'b0, 2'b11);
    check_val("rst_pre_count", 32'(bus.count), 3);
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    cyc(1'b1, 1'b1, 2'b11);
    check_val("rst_pre_valid", 32'(bus.valid_out), 1);
    reset_L = 1'b0;
    #1;
    check_idle("rst_async");
    bus.push = 1'b0;
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 2'b00);
    check_val("rst_pop_valid", 32'(bus.valid_out), 0);
    check_val("rst_pop_count", 32'(bus.count), 0);
    do_reset();

    // Basic FIFO order.
    cyc(1'b1, 1'b0, 2'b01);
    cyc(1'b1, 1'b0, 2'b10);
    cyc(1'b1, 1'b0, 2'b11);
    check_val("ord_count", 32'(bus.count), 3);
    cyc(1'b0, 1'b1, 2'b00);
    check_val("ord_v0", 32'(bus.valid_out), 1);
    check_val("ord_d0", 32'(bus.data_out), 2'b01);
    cyc(1'b0, 1'b1, 2'b00);
    check_val("ord_d1", 32'(bus.data_out), 2'b10);
    cyc(1'b0, 1'b1, 2'b00);
    check_val("ord_d2", 32'(bus.data_out), 2'b11);
    check_val("ord_empty", 32'(bus.empty), 1);
    check_val("ord_count0", 32'(bus.count), 0);
    cyc(1'b0, 1'b0, 2'b00);
    check_val("ord_idle_v", 32'(bus.valid_out), 0);
    check_val("ord_idle_d", 32'(bus.data_out), 0);
    check_val("ord_err", 32'(bus.error), 0);

    // Fill to full and verify thresholds.
    fill_words = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, fill_words[i]);
      check_val($sformatf("fill_count%0d", i), 32'(bus.count), 32'(i + 1));
      check_val($sformatf("fill_af%0d", i), 32'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
      check_val($sformatf("fill_ae%0d", i), 32'(bus.almost_empty), (i + 1 <= 1) ? 1 : 0);
    end
    check_val("fill_full", 32'(bus.full), 1);
    check_val("fill_err0", 32'(bus.error), 0);
    cyc(1'b1, 1'b0, 2'b11);
    check_val("ovf_err", 32'(bus.error), 1);
    check_val("ovf_count", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 2'b00);
      check_val($sformatf("drain_v%0d", i), 32'(bus.valid_out), 1);
      check_val($sformatf("drain_d%0d", i), 32'(bus.data_out), 32'(fill_words[i]));
    end
    check_val("drain_empty", 32'(bus.empty), 1);
    check_val("drain_err_sticky", 32'(bus.error), 1);

    // Push and pop together while full.
    do_reset();
    check_val("fp_err_clr", 32'(bus.error), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, fill_words[i]);
    cyc(1'b1, 1'b1, 2'b00);
    check_val("fp_count", 32'(bus.count), 8);
    check_val("fp_err", 32'(bus.error), 0);
    check_val("fp_v", 32'(bus.valid_out), 1);
    check_val("fp_d", 32'(bus.data_out), 2'b11);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 1'b1, 2'b00);
      check_val($sformatf("fp_drain%0d", i), 32'(bus.data_out), 32'(fill_words[i]));
    end
    cyc(1'b0, 1'b1, 2'b00);
    check_val("fp_last_v", 32'(bus.valid_out), 1);
    check_val("fp_last_d", 32'(bus.data_out), 2'b00);
    check_val("fp_last_empty", 32'(bus.empty), 1);

    // Underflow with concurrent push.
    do_reset();
    cyc(1'b1, 1'b1, 2'b10);
    check_val("unf_err", 32'(bus.error), 1);
    check_val("unf_v", 32'(bus.valid_out), 0);
    check_val("unf_count", 32'(bus.count), 1);
    cyc(1'b0, 1'b1, 2'b00);
    check_val("unf_pop_v", 32'(bus.valid_out), 1);
    check_val("unf_pop_d", 32'(bus.data_out), 2'b10);

    // Steady occupancy of 3 with simultaneous push/pop across pointer wrap.
    do_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      w = 2'(i + 1);
      q.push_back(w);
      cyc(1'b1, 1'b0, w);
    end
    for (int i = 0; i < 20; i++) begin
      w = 2'($urandom_range(0, 3));
      q.push_back(w);
      cyc(1'b1, 1'b1, w);
      check_val($sformatf("wrap_v%0d", i), 32'(bus.valid_out), 1);
      check_val($sformatf("wrap_d%0d", i), 32'(bus.data_out), 32'(q.pop_front()));
    end
    check_val("wrap_count", 32'(bus.count), 3);
    check_val("wrap_err", 32'(bus.error), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_entrada.md
Name: fifo_entrada

Overview:
Synchronous FIFO that buffers incoming words and feeds the 2:1 mux stage directly downstream. Its registered data_out/valid_out pair drives one mux data/valid input pair. Its almost_full/almost_empty flags drive upstream flow control and the mux selector logic. One instance per mux input.

Parameters:
DATA_WIDTH, 2, width of each stored word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (8 entries)
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous, active-low reset
data_in  input  DATA_WIDTH  word to write
push  input  1  write request, sampled at posedge clk
pop  input  1  read request, sampled at posedge clk
data_out  output  DATA_WIDTH  registered read data, to mux Entrada0/1
valid_out  output  1  data_out carries a popped word this cycle, to mux validEntrada0/1
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
error  output  1  sticky overflow/underflow flag
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock (clk); reset_L is asynchronous and active-low.
- Reset (reset_L=0, any time, including mid-operation): the block clears wr_ptr, rd_ptr, and count to 0, and sets data_out=0, valid_out=0, and error=0 immediately. Flags become empty=1, almost_empty=1, full=0, almost_full=0. Storage array is not cleared. Push and pop are ignored while reset_L=0.
- Pointers: ADDR_WIDTH bits, increment modulo DEPTH, wrap 7->0.
- Push accepted = push & (!full | pop_accepted). Write mem[wr_ptr] <= data_in and increment wr_ptr at posedge.
- Pop accepted = pop & !empty. At posedge: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr++. This gives 1-cycle latency from the pop edge to valid data.
- Cycle with no accepted pop: valid_out <= 0 and data_out <= 0. The mux therefore never sees stale data flagged valid.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags are combinational decodes of count. They are valid in the same cycle count changes.
- Full with push & pop: pop is accepted and the push is accepted into the freed slot. count stays DEPTH, no error.
- Full with push only: write is dropped, memory and pointers unchanged, error <= 1.
- Empty with pop (with or without push): pop is ignored and error <= 1. valid_out <= 0. A concurrent push is accepted, so count becomes 1. No write-through bypass: the word becomes readable the following cycle.
- error is sticky; only reset_L clears it.
- Ordering is strict FIFO, with no reordering across wrap-around.

Test Plan:
- Reset behaviour: hold reset_L=0 while push=1 and data_in=2'b11, then assert reset_L=0 asynchronously mid-stream after 3 pushes -> all outputs return to reset values before the next clk edge, count=0, and the following pops produce no valid_out.
- Basic order: push 2'b01, 2'b10, 2'b11 on consecutive cycles, then pop 3 times -> valid_out=1 with data_out 01,10,11 on the cycles after each pop edge, then empty=1 and count=0.
- Fill and thresholds: push 8 words with no pop -> almost_full rises when count=6, full=1 at count=8. A 9th push sets error=1, count stays 8, and the next 8 pops return the original 8 words.
- Full push+pop: at count=8, push 2'b00 with pop -> count stays 8, error stays 0, and the popped word is the oldest entry.
- Underflow: from reset, pop=1 with push=1 and data_in=2'b10 -> error=1, valid_out=0, count=1. The next pop yields data_out=2'b10 with valid_out=1.
- Wrap-around: run 20 cycles with push and pop both asserted on a random data stream and occupancy held at 3 -> output equals the input delayed by 3 accepted entries, the pointers wrap past 7, and error stays 0.
